// File: rtl/pipe_sub32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_sub32 : 4-stage pipelined 32-bit subtractor, one byte per stage,    |
// |              with per-stage stall, flush and valid tagging.              |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module pipe_sub32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  stop,
  input  logic [3:0]  flush,
  output logic        out_valid,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        ovf
);

  logic [4:1]  r_v;
  logic [4:1]  r_br;
  logic [31:0] r_d [1:4];
  logic [31:0] r_a [1:3];
  logic [31:0] r_b [1:3];
  logic        r_ovf;

  logic        w_stop_oh;
  logic        w_flush_oh;
  logic [4:1]  w_hold;
  logic [4:1]  w_bubble;
  logic [4:1]  w_clr;
  logic [4:1]  w_v_in;
  logic [4:1]  w_br_in;
  logic [4:1]  w_br_new;
  logic [31:0] w_a_in  [1:4];
  logic [31:0] w_b_in  [1:4];
  logic [31:0] w_d_in  [1:4];
  logic [31:0] w_d_new [1:4];
  logic [8:0]  w_seg   [1:4];
  logic        w_ovf_new;

  // Non-one-hot stop/flush codes are treated as idle.
  assign w_stop_oh  = (stop  != 4'd0) && ((stop  & (stop  - 4'd1)) == 4'd0);
  assign w_flush_oh = (flush != 4'd0) && ((flush & (flush - 4'd1)) == 4'd0);
  assign in_ready   = ~w_stop_oh;

  always_comb begin
    w_a_in[1]   = a;
    w_b_in[1]   = b;
    w_d_in[1]   = 32'd0;
    w_br_in[1]  = 1'b0;
    w_v_in[1]   = in_valid & in_ready;
    w_bubble[1] = 1'b0;
    for (int m = 2; m <= 4; m++) begin
      w_a_in[m]   = r_a[m-1];
      w_b_in[m]   = r_b[m-1];
      w_d_in[m]   = r_d[m-1];
      w_br_in[m]  = r_br[m-1];
      w_v_in[m]   = r_v[m-1];
      w_bubble[m] = w_stop_oh && stop[m-2];
    end
    for (int m = 1; m <= 4; m++) begin
      // A stall at stage k freezes every stage at or below k.
      w_hold[m]   = w_stop_oh && ((stop >> (m-1)) != 4'd0);
      w_clr[m]    = w_flush_oh && flush[m-1];
      w_seg[m]    = {1'b0, w_a_in[m][8*m-1 -: 8]} - {1'b0, w_b_in[m][8*m-1 -: 8]}
                    - {8'd0, w_br_in[m]};
      w_d_new[m]  = w_d_in[m];
      w_d_new[m][8*m-8 +: 8] = w_seg[m][7:0];
      w_br_new[m] = w_seg[m][8];
    end
    w_ovf_new = (w_a_in[4][31] != w_b_in[4][31]) && (w_d_new[4][31] != w_a_in[4][31]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v   <= '0;
      r_br  <= '0;
      r_ovf <= 1'b0;
      for (int m = 1; m <= 4; m++) r_d[m] <= '0;
      for (int m = 1; m <= 3; m++) begin
        r_a[m] <= '0;
        r_b[m] <= '0;
      end
    end else begin
      for (int m = 1; m <= 4; m++) begin
        if (w_clr[m]) begin
          r_v[m]  <= 1'b0;
          r_d[m]  <= '0;
          r_br[m] <= 1'b0;
        end else if (!w_hold[m]) begin
          r_v[m]  <= w_v_in[m] & ~w_bubble[m];
          r_d[m]  <= w_d_new[m];
          r_br[m] <= w_br_new[m];
        end
      end
      for (int m = 1; m <= 3; m++) begin
        if (w_clr[m]) begin
          r_a[m] <= '0;
          r_b[m] <= '0;
        end else if (!w_hold[m]) begin
          r_a[m] <= w_a_in[m];
          r_b[m] <= w_b_in[m];
        end
      end
      if (w_clr[4])
        r_ovf <= 1'b0;
      else if (!w_hold[4])
        r_ovf <= w_ovf_new;
    end
  end

  assign out_valid = r_v[4];
  assign diff      = r_d[4];
  assign borrow    = r_br[4];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sub32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_sub32 : self-checking bench for pipe_sub32 (slot model + vectors)|
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_sub32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  stop;
  logic [3:0]  flush;
  logic        out_valid;
  logic [31:0] diff;
  logic        borrow;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [33:0] got_q [$];
  int          got_cyc [$];

  bit          m_v [1:4];
  logic [31:0] m_a [1:4];
  logic [31:0] m_b [1:4];

  pipe_sub32 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .stop(stop), .flush(flush),
    .out_valid(out_valid), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic bit onehot(input logic [3:0] x);
    return $countones(x) == 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] got(input int i);
    if (got_q.size() > i) return got_q[i];
    return '1;
  endfunction

  function automatic int span();
    if (got_cyc.size() < 1) return -1;
    return got_cyc[got_cyc.size()-1] - got_cyc[0];
  endfunction

  // Each slot holds the operand pair that is in flight at that depth.
  always @(posedge clk) begin : model
    int          sidx;
    bit          n_v [1:4];
    logic [31:0] n_a [1:4];
    logic [31:0] n_b [1:4];
    sidx = 0;
    if (onehot(stop))
      for (int k = 0; k < 4; k++) if (stop[k]) sidx = k + 1;
    for (int k = 1; k <= 4; k++) begin
      n_v[k] = m_v[k]; n_a[k] = m_a[k]; n_b[k] = m_b[k];
      if (k <= sidx) begin
      end else if (sidx != 0 && k == sidx + 1) begin
        n_v[k] = 1'b0;
      end else if (k == 1) begin
        n_v[k] = in_valid; n_a[k] = a; n_b[k] = b;
      end else begin
        n_v[k] = m_v[k-1]; n_a[k] = m_a[k-1]; n_b[k] = m_b[k-1];
      end
      if (onehot(flush) && flush[k-1]) n_v[k] = 1'b0;
      if (reset) n_v[k] = 1'b0;
    end
    for (int k = 1; k <= 4; k++) begin
      m_v[k] = n_v[k]; m_a[k] = n_a[k]; m_b[k] = n_b[k];
    end
  end

  always @(posedge clk) begin : compare
    logic [31:0] e_d;
    #1;
    cyc++;
    chk("in_ready", {63'd0, in_ready}, {63'd0, !onehot(stop)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_v[4]});
    if (m_v[4]) begin
      e_d = m_a[4] - m_b[4];
      chk("diff", {32'd0, diff}, {32'd0, e_d});
      chk("borrow", {63'd0, borrow}, {63'd0, m_a[4] < m_b[4]});
      chk("ovf", {63'd0, ovf},
          {63'd0, (m_a[4][31] != m_b[4][31]) && (e_d[31] != m_a[4][31])});
    end
    if (out_valid === 1'b1) begin
      got_q.push_back({ovf, borrow, diff});
      got_cyc.push_back(cyc);
    end
  end

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [3:0] ist = 4'd0, input logic [3:0] ifl = 4'd0);
    in_valid = iv; a = ia; b = ib; stop = ist; flush = ifl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 32'd0);
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    int          j;
    logic [3:0]  st;
    logic [31:0] ea;
    logic [31:0] eb;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; stop = '0; flush = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff", {32'd0, diff}, 64'd0);
    chk("rst_borrow_ovf", {62'd0, borrow, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic latency: result visible after the 4th edge, for one cycle only.
    clear_log();
    step(1'b1, 32'd5, 32'd3);
    idle(2);
    chk("t1_early", {63'd0, out_valid}, 64'd0);
    idle(1);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_diff", {32'd0, diff}, 64'h2);
    chk("t1_flags", {62'd0, borrow, ovf}, 64'd0);
    idle(1);
    chk("t1_once", {63'd0, out_valid}, 64'd0);

    // Wrap, signed overflow, cross-segment borrow.
    clear_log();
    step(1'b1, 32'd3, 32'd5);
    step(1'b1, 32'h8000_0000, 32'h1);
    step(1'b1, 32'h0000_0100, 32'h1);
    idle(5);
    chk("t2_count", got_q.size(), 64'd3);
    chk("t2_r0", {30'd0, got(0)}, {30'd0, 1'b0, 1'b1, 32'hFFFF_FFFE});
    chk("t2_r1", {30'd0, got(1)}, {30'd0, 1'b1, 1'b0, 32'h7FFF_FFFF});
    chk("t2_r2", {30'd0, got(2)}, {30'd0, 2'b00, 32'h0000_00FF});

    // Back-to-back stream: i*0x01010101 - i = i*0x01010100.
    clear_log();
    for (int i = 1; i <= 8; i++) step(1'b1, i * 32'h0101_0101, i);
    idle(5);
    chk("t3_count", got_q.size(), 64'd8);
    for (int i = 1; i <= 8; i++)
      chk("t3_diff", {30'd0, got(i-1)}, {32'd0, i * 32'h0101_0100});
    chk("t3_span", span(), 64'd7);

    // Stall stage 3 for two cycles mid-stream.
    clear_log();
    j = 0;
    for (int t = 0; t < 40 && j < 8; t++) begin
      st = (t == 5 || t == 6) ? 4'b0100 : 4'b0000;
      step(1'b1, 32'h1234_5678 + j * 32'h0100_0001, j * 32'h00FF_00FF, st);
      if (st != 4'd0) chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
      else j++;
    end
    idle(8);
    chk("t4_count", got_q.size(), 64'd8);
    for (int i = 0; i < 8; i++) begin
      ea = 32'h1234_5678 + i * 32'h0100_0001;
      eb = i * 32'h00FF_00FF;
      chk("t4_diff", {32'd0, got(i)[31:0]}, {32'd0, ea - eb});
    end
    chk("t4_span", span(), 64'd9);

    // Flush drops the item entering stage 2; neighbours survive.
    clear_log();
    step(1'b1, 32'h50, 32'h10);
    step(1'b1, 32'h60, 32'h10);
    step(1'b1, 32'h70, 32'h10, 4'b0000, 4'b0010);
    idle(5);
    chk("t5_count", got_q.size(), 64'd2);
    chk("t5_r0", {32'd0, got(0)[31:0]}, 64'h40);
    chk("t5_r1", {32'd0, got(1)[31:0]}, 64'h60);

    // Multi-bit stop code is not a stall.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h100 + i, 32'h1, 4'b0011);
      chk("t5_nostall_rdy", {63'd0, in_ready}, 64'd1);
    end
    idle(5);
    chk("t5_nostall_cnt", got_q.size(), 64'd4);
    chk("t5_nostall_span", span(), 64'd3);

    // Whole-pipe freeze holds the output.
    step(1'b1, 32'h10, 32'h20);
    idle(3);
    chk("frz_valid0", {63'd0, out_valid}, 64'd1);
    step(1'b0, 32'd0, 32'd0, 4'b1000);
    chk("frz_valid1", {63'd0, out_valid}, 64'd1);
    chk("frz_diff", {32'd0, diff}, 64'hFFFF_FFF0);
    idle(1);
    chk("frz_release", {63'd0, out_valid}, 64'd0);

    // Reset with items in flight, then a fresh item.
    step(1'b1, 32'd1, 32'd1);
    step(1'b1, 32'd2, 32'd1);
    step(1'b1, 32'd3, 32'd1);
    clear_log();
    reset = 1'b1;
    step(1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_diff", {32'd0, diff}, 64'd0);
    chk("t6_flags", {62'd0, borrow, ovf}, 64'd0);
    idle(4);
    chk("t6_discard", got_q.size(), 64'd0);
    step(1'b1, 32'd0, 32'd1);
    idle(2);
    chk("t6_early", {63'd0, out_valid}, 64'd0);
    idle(1);
    chk("t6_late_valid", {63'd0, out_valid}, 64'd1);
    chk("t6_late_diff", {32'd0, diff}, 64'hFFFF_FFFF);
    chk("t6_late_flags", {62'd0, borrow, ovf}, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
